// File: rtl/rr_prio_encoder.sv
// Purpose    : registered priority encoder. Fixed mode picks the highest set request bit;
//              round-robin mode scans downward from a rotating pointer.
// Latency    : 1 cycle. The result is registered on the edge that accepts the input.
// Backpressure: valid/ready. in_ready = !out_valid || out_ready, and the held result stays
//              stable while it is stalled.
// Ports:
//   clk, rst_n          - clock (rising edge); asynchronous active-low reset
//   data_in, mode_rr    - request vector and mode (1 = round-robin), qualified by in_valid
//   in_valid, in_ready  - input handshake
//   encoded_out         - index of the winning request
//   onehot_out          - one-hot of the winning request
//   valid_out           - high when at least one request bit was set
//   out_valid, out_ready- output handshake
module rr_prio_encoder #(
  parameter int N     = 8,
  parameter int OUT_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     data_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode_rr,
  output logic [OUT_W-1:0] encoded_out,
  output logic [N-1:0]     onehot_out,
  output logic             valid_out,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [OUT_W-1:0] LP_LAST = OUT_W'(N - 1);

  logic [OUT_W-1:0] r_ptr;
  logic [OUT_W-1:0] r_encoded;
  logic [N-1:0]     r_onehot;
  logic             r_valid_out;
  logic             r_out_valid;

  logic             w_xfer;
  logic             w_any;
  logic [OUT_W-1:0] w_start;
  logic [OUT_W-1:0] w_win;
  logic [N-1:0]     w_onehot;
  logic [OUT_W-1:0] w_ptr_nxt;
  int               w_idx;

  assign in_ready = !r_out_valid || out_ready;
  assign w_xfer   = in_valid && in_ready;
  assign w_any    = |data_in;

  // Fixed priority is a downward scan that starts at N-1, so both modes share one
  // scanner. Positions are visited from farthest to nearest and the last hit wins,
  // which leaves the position closest to the start as the winner. The wrap uses
  // modulo N arithmetic, so a non-power-of-2 N never produces an index above N-1.
  always_comb begin
    w_start = mode_rr ? r_ptr : LP_LAST;
    w_win   = '0;
    w_idx   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = int'(w_start) - k;
      if (w_idx < 0) begin
        w_idx = w_idx + N;
      end
      if (data_in[w_idx[OUT_W-1:0]]) begin
        w_win = w_idx[OUT_W-1:0];
      end
    end
  end

  always_comb begin
    w_onehot = '0;
    if (w_any) begin
      w_onehot[w_win] = 1'b1;
    end
  end

  // After a round-robin grant, the next scan starts just below the winner.
  // Index 0 wraps to N-1.
  assign w_ptr_nxt = (w_win == '0) ? LP_LAST : (w_win - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= LP_LAST;
      r_encoded   <= '0;
      r_onehot    <= '0;
      r_valid_out <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_encoded   <= w_win;
        r_onehot    <= w_onehot;
        r_valid_out <= w_any;
        r_out_valid <= 1'b1;
        if (mode_rr && w_any) begin
          r_ptr <= w_ptr_nxt;
        end
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign encoded_out = r_encoded;
  assign onehot_out  = r_onehot;
  assign valid_out   = r_valid_out;
  assign out_valid   = r_out_valid;

endmodule
